// File: rtl/clock_lock_sequencer_if.sv
// clock_lock_sequencer_if: lock inputs and staged reset/status outputs.
// The master side drives locked; the sequencer (slave) drives the rest.
interface clock_lock_sequencer_if #(
    parameter int NumLocks  = 2,
    parameter int NumStages = 3
);
    logic [NumLocks-1:0]  locked;
    logic                 cm_reset;
    logic [NumStages-1:0] stage_reset;
    logic                 ready;
    logic [3:0]           loss_count;
    logic [7:0]           status;

    modport master (
        output locked,
        input  cm_reset,
        input  stage_reset,
        input  ready,
        input  loss_count,
        input  status
    );

    modport slave (
        input  locked,
        output cm_reset,
        output stage_reset,
        output ready,
        output loss_count,
        output status
    );
endinterface

// File: rtl/clock_lock_sequencer.sv
// clock_lock_sequencer: pulses clock-manager reset, waits for stable lock,
// releases reset stages in order. LOCK_TIMEOUT_EN adds a WAIT_LOCK timeout.
module clock_lock_sequencer #(
    parameter int NumLocks      = 2,
    parameter int NumStages     = 3,
    parameter int PulseCycles   = 16,
    parameter int StableCycles  = 256,
    parameter int ReleaseGap    = 16,
    parameter int TimeoutCycles = 65536
) (
    input logic                   clock,
    input logic                   reset,
    clock_lock_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        PULSE     = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_e;

    if (PulseCycles < 1 || StableCycles < 1 ||
        ReleaseGap < 1 || TimeoutCycles < 1) begin : g_bad_cfg
        $error("clock_lock_sequencer: cycle parameters must be >= 1");
    end

    localparam int MaxPs  = (PulseCycles > StableCycles) ?
                            PulseCycles : StableCycles;
    localparam int MaxCnt = (MaxPs > ReleaseGap) ? MaxPs : ReleaseGap;
    localparam int CntW   = $clog2(MaxCnt + 1);

    localparam logic [CntW-1:0] PulseLast  = CntW'(PulseCycles - 1);
    localparam logic [CntW-1:0] StableLast = CntW'(StableCycles - 1);
    localparam logic [CntW-1:0] GapLast    = CntW'(ReleaseGap - 1);
    localparam logic [NumStages-1:0] StageFirst = NumStages'(1);

    logic [NumLocks-1:0]  sync1_q, sync2_q;
    logic                 all_locked;
    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [NumStages-1:0] stage_q, stage_d;
    logic [2:0]           retry_q, retry_d;
    logic [3:0]           loss_q, loss_d;
    logic                 go_pulse;
    logic                 tmo_hit;

    // Two-flop synchronizer for the asynchronous lock flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.locked;
            sync2_q <= sync1_q;
        end
    end

    assign all_locked = &sync2_q;

`ifdef LOCK_TIMEOUT_EN
    localparam int TmoW = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    logic [TmoW-1:0] tmo_q, tmo_d;

    // Count cycles spent in WAIT_LOCK; held at zero everywhere else.
    always_comb begin
        tmo_d = '0;
        if (state_q == WAIT_LOCK) tmo_d = tmo_q + 1'b1;
    end

    // Timeout counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end

    assign tmo_hit = (state_q == WAIT_LOCK) && (tmo_q == TmoLast);
`else
    assign tmo_hit = 1'b0;
`endif

    // Next-state logic; lock loss overrides any release or count event.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        retry_d  = retry_q;
        loss_d   = loss_q;
        go_pulse = 1'b0;
        unique case (state_q)
            PULSE: begin
                if (cnt_q == PulseLast) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (all_locked && cnt_q == StableLast) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    stage_d = StageFirst;
                end else begin
                    if (all_locked) cnt_d = cnt_q + 1'b1;
                    else            cnt_d = '0;
                    if (tmo_hit) go_pulse = 1'b1;
                end
            end
            RELEASE: begin
                if (!all_locked) begin
                    go_pulse = 1'b1;
                end else if (stage_q[NumStages-1]) begin
                    state_d = RUN;
                end else if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    stage_d = (stage_q << 1) | StageFirst;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!all_locked) begin
                    go_pulse = 1'b1;
                    if (loss_q != 4'hf) loss_d = loss_q + 1'b1;
                end
            end
        endcase
        if (go_pulse) begin
            state_d = PULSE;
            cnt_d   = '0;
            stage_d = '0;
            if (retry_q != 3'h7) retry_d = retry_q + 1'b1;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= PULSE;
            cnt_q   <= '0;
            stage_q <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    assign bus.cm_reset    = (state_q != PULSE);
    assign bus.stage_reset = stage_q;
    assign bus.ready       = (state_q == RUN);
    assign bus.loss_count  = loss_q;
    assign bus.status      = {state_q, retry_q, loss_q[2:0]};
endmodule

// File: tb/tb_clock_lock_sequencer.sv
// tb_clock_lock_sequencer: scoreboard bench with a timeline reference model.
// Expected outputs per cycle are queued by the driver, checked by a monitor.
module tb_clock_lock_sequencer;
    localparam int NL   = 2;
    localparam int NS   = 3;
    localparam int P    = 4;
    localparam int S    = 8;
    localparam int G    = 4;
    localparam int T    = 64;
    localparam int MAXL = 1600;

    typedef struct packed {
        logic          cm;
        logic [NS-1:0] stg;
        logic          rdy;
        logic [3:0]    loss;
        logic [7:0]    status;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    clock_lock_sequencer_if #(.NumLocks(NL), .NumStages(NS)) bus();

    clock_lock_sequencer #(
        .NumLocks(NL), .NumStages(NS), .PulseCycles(P),
        .StableCycles(S), .ReleaseGap(G), .TimeoutCycles(T)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus(bus)
    );

    logic [NL-1:0] lk [MAXL+2];
    exp_t          ex [MAXL+2];
    exp_t          q [$];
    int            tq [$];
    int            n_chk = 0;
    int            n_fail = 0;
    string         scn = "";
    exp_t          mon_e, mon_a;
    int            mon_t;

    function automatic exp_t mk(input int st, input int nst,
                                input int ret, input int los);
        exp_t e;
        e.cm     = (st != 0);
        e.stg    = NS'((1 << nst) - 1);
        e.rdy    = (st == 3);
        e.loss   = 4'(los);
        e.status = {st[1:0], ret[2:0], los[2:0]};
        return e;
    endfunction

    // Timeline model: walks phases by start time using the sync'd lock trace.
    task automatic build_model(input int len);
        bit al [MAXL+2];
        int t, m, k, run, nxt, ret, los;
        for (int i = 0; i <= len; i++)
            al[i] = (i >= 2) && (&lk[i-1]);
        t = 0; m = 0; ret = 0; los = 0;
        while (t <= len) begin
            nxt = -1;
            k = t;
            case (m)
                0: begin
                    for (k = t; k < t + P && k <= len; k++)
                        ex[k] = mk(0, 0, ret, los);
                    t = t + P;
                    m = 1;
                end
                1: begin
                    run = 0;
                    while (k <= len && nxt < 0) begin
                        ex[k] = mk(1, 0, ret, los);
                        run = al[k] ? run + 1 : 0;
                        if (run == S) nxt = 2;
`ifdef LOCK_TIMEOUT_EN
                        else if (k == t + T - 1) nxt = 0;
`endif
                        k++;
                    end
                    t = k;
                    if (nxt == 0) begin
                        if (ret < 7) ret++;
                        m = 0;
                    end else if (nxt == 2) begin
                        m = 2;
                    end
                end
                2: begin
                    while (k <= len && k <= t + (NS - 1) * G && nxt < 0) begin
                        ex[k] = mk(2, 1 + (k - t) / G, ret, los);
                        if (!al[k]) nxt = 0;
                        k++;
                    end
                    if (nxt == 0) begin
                        if (ret < 7) ret++;
                        m = 0;
                    end else if (k > t + (NS - 1) * G) begin
                        m = 3;
                    end
                    t = k;
                end
                default: begin
                    while (k <= len && nxt < 0) begin
                        ex[k] = mk(3, NS, ret, los);
                        if (!al[k]) nxt = 0;
                        k++;
                    end
                    if (nxt == 0) begin
                        if (ret < 7) ret++;
                        if (los < 15) los++;
                        m = 0;
                    end
                    t = k;
                end
            endcase
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s/%s got=%0d want=%0d", scn, name, act, req);
        end
    endtask

    task automatic chk_rst();
        exp_t a, e;
        a = {bus.cm_reset, bus.stage_reset, bus.ready,
             bus.loss_count, bus.status};
        e = mk(0, 0, 0, 0);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s/async_reset got=%h want=%h", scn, a, e);
        end
    endtask

    // Scoreboard monitor: one queued expectation per cycle, mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            mon_t = tq.pop_front();
            mon_a = {bus.cm_reset, bus.stage_reset, bus.ready,
                     bus.loss_count, bus.status};
            n_chk++;
            if (mon_a !== mon_e) begin
                n_fail++;
                $display("FAIL %s/cyc%0d got cm=%b stg=%b rdy=%b loss=%0d st=%h want cm=%b stg=%b rdy=%b loss=%0d st=%h",
                         scn, mon_t, mon_a.cm, mon_a.stg, mon_a.rdy,
                         mon_a.loss, mon_a.status, mon_e.cm, mon_e.stg,
                         mon_e.rdy, mon_e.loss, mon_e.status);
            end
        end
    end

    task automatic run_scn(input string name, input int len);
        rst_n = 1'b0;
        #1;
        scn = name;
        chk_rst();
        build_model(len);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        bus.locked = lk[1];
        for (int k = 1; k <= len; k++) begin
            q.push_back(ex[k]);
            tq.push_back(k);
            @(posedge clk);
            #2;
            bus.locked = lk[k + 1];
        end
        @(negedge clk);
        #1;
        chk("drain", q.size(), 0);
    endtask

    task automatic fill(input int len, input logic [NL-1:0] v);
        for (int k = 0; k <= len + 1; k++) lk[k] = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, seg, len;
        logic [NL-1:0] v;
        bus.locked = '0;
        #3;

        fill(40, 2'b11);
        run_scn("powerup", 40);
        chk("ready", int'(bus.ready), 1);
        chk("state", int'(bus.status[7:6]), 3);
        chk("stages", int'(bus.stage_reset), 7);

        fill(40, 2'b11);
        lk[8] = 2'b01;
        run_scn("wait_glitch", 40);

        fill(70, 2'b11);
        lk[30] = 2'b10;
        run_scn("run_loss", 70);
        chk("loss1", int'(bus.loss_count), 1);
        chk("retry1", int'(bus.status[5:3]), 1);

        fill(50, 2'b11);
        lk[13] = 2'b00;
        run_scn("rel_loss", 50);
        chk("rel_loss0", int'(bus.loss_count), 0);

        fill(560, 2'b00);
        run_scn("no_lock", 560);
`ifdef LOCK_TIMEOUT_EN
        chk("retry_sat", int'(bus.status[5:3]), 7);
`else
        chk("wait_hold", int'(bus.status[7:6]), 1);
`endif

        fill(14, 2'b11);
        run_scn("mid_release", 14);

        k = 1;
        for (int r = 0; r < 17; r++) begin
            seg = $urandom_range(32, 40);
            for (int j = 0; j < seg; j++) begin lk[k] = 2'b11; k++; end
            seg = $urandom_range(1, 3);
            for (int j = 0; j < seg; j++) begin
                v = NL'($urandom_range(0, 2));
                lk[k] = v;
                k++;
            end
        end
        for (int j = 0; j < 40; j++) begin lk[k] = 2'b11; k++; end
        len = k - 2;
        run_scn("loss_sat", len);
        chk("loss_sat", int'(bus.loss_count), 15);
        chk("retry_sat7", int'(bus.status[5:3]), 7);

        len = 1200;
        k = 1;
        while (k <= len + 1) begin
            if ($urandom_range(0, 2) != 0) begin
                seg = $urandom_range(1, 40);
                v = '1;
            end else begin
                seg = $urandom_range(1, 4);
                v = NL'($urandom_range(0, 3));
            end
            for (int j = 0; j < seg && k <= len + 1; j++) begin
                lk[k] = v;
                k++;
            end
        end
        run_scn("random", len);

        rst_n = 1'b0;
        #1;
        scn = "final";
        chk_rst();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/clock_lock_sequencer.md
Name: clock_lock_sequencer

Overview:
- Parametrised power-up and relock sequencer for N clock managers.
- Replaces the ad-hoc "reset & locked & locked" gating in FPGA top levels.
- Pulses the clock-manager reset, waits for all lock inputs to be stable, then releases downstream reset domains one stage at a time.
- On any loss of lock it re-asserts every stage reset and retries. Exports status for the LEDs.

Parameters:
- NumLocks, 2: number of clock-manager locked inputs.
- NumStages, 3: number of staged active-low reset outputs.
- PulseCycles, 16: length of the clock-manager reset pulse, in cycles; must be >= 1.
- StableCycles, 256: consecutive cycles all locks must be high before release; must be >= 1.
- ReleaseGap, 16: cycles between successive stage releases; must be >= 1.
- TimeoutCycles, 65536: cycles in WAIT_LOCK before a retry. Used only when LOCK_TIMEOUT_EN is defined.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- locked  in  NumLocks  clock-manager lock flags; asynchronous to clock.
- cm_reset  out  1  active-low reset to the clock managers.
- stage_reset  out  NumStages  active-low reset per downstream domain; bit 0 is released first.
- ready  out  1  high when all stages are released and the FSM is in RUN.
- loss_count  out  4  number of lock-loss events in RUN; saturates at 15.
- status  out  8  {state[1:0], retry_count[2:0], loss_count[2:0]}; intended for the LEDs.

Behaviour:
- Reset values (reset low, asynchronous):
  - FSM in PULSE.
  - cm_reset=0, stage_reset=all 0, ready=0.
  - All counters 0, synchronizers 0.
- Lock synchronisation:
  - Each locked bit passes through a 2-flop synchronizer.
  - all_locked = AND of the synchronized bits. It lags the inputs by 2 cycles.
- State encoding: PULSE=0, WAIT_LOCK=1, RELEASE=2, RUN=3.
- PULSE:
  - cm_reset=0 for exactly PulseCycles cycles, then go to WAIT_LOCK.
  - cm_reset=1 in every state except PULSE.
- WAIT_LOCK:
  - stab_cnt increments while all_locked=1 and clears to 0 whenever all_locked=0.
  - When stab_cnt reaches StableCycles-1 with all_locked=1, go to RELEASE on the next edge.
  - With LOCK_TIMEOUT_EN: see Optional Feature.
- RELEASE:
  - On entry, stage_reset[0] goes to 1 in the same cycle the state register becomes RELEASE.
  - Each following stage k goes to 1 exactly ReleaseGap cycles after stage k-1.
  - Once stage_reset[NumStages-1]=1, the next edge enters RUN.
  - ready=1 in the cycle the state is RUN.
- RUN:
  - Hold all outputs released.
- Lock loss (RELEASE or RUN):
  - If all_locked=0 in RELEASE or RUN, on the next edge: stage_reset=all 0, ready=0, state=PULSE.
  - All released stages drop together.
  - loss_count increments (saturating) only when the loss occurs in RUN.
- retry_count: 3-bit, saturating at 7.
  - Increments on every transition into PULSE other than from reset.
  - Cleared only by reset.
- Counter widths: sized to hold the largest of PulseCycles, StableCycles, ReleaseGap and TimeoutCycles. One shared down-counter is acceptable.
- Simultaneous events: lock loss takes priority over stage-release and stable-count completion in the same cycle.
- Reset asserted mid-sequence returns immediately to the reset values. Counters are not preserved.
- status[7:6] is the state encoding; status[2:0] is loss_count[2:0].

Optional Feature:
- Macro: LOCK_TIMEOUT_EN.
- Defined:
  - A WAIT_LOCK cycle counter runs, cleared on entry to WAIT_LOCK.
  - If it reaches TimeoutCycles-1 without leaving WAIT_LOCK, the next edge goes to PULSE and retry_count increments.
- Not defined:
  - WAIT_LOCK waits indefinitely.
  - The TimeoutCycles parameter is ignored and no timeout counter is built.

Test Plan:
Settings: NumLocks=2, NumStages=3, PulseCycles=4, StableCycles=8, ReleaseGap=4, TimeoutCycles=64.
1. Release reset; locked=2'b11 from cycle 0 -> cm_reset low cycles 0-3; stage_reset 001, 011, 111 at 4-cycle spacing after 8 stable cycles (+2 sync); ready=1 the cycle after 111; status[7:6]=3.
2. In WAIT_LOCK, drop locked[1] for 1 cycle at stab_cnt=5 -> stab_cnt clears; release is delayed by the full 8 cycles after relock.
3. In RUN, drop locked[0] -> 3 cycles later stage_reset=000, ready=0, cm_reset=0 for 4 cycles; loss_count=1, retry_count=1.
4. Lose lock in RELEASE after stage 0 only -> stage_reset=000 next edge; loss_count stays 0; retry_count increments.
5. LOCK_TIMEOUT_EN defined, locked held 0 -> PULSE re-entered every 4+64 cycles; retry_count saturates at 7. Without the macro -> stays in WAIT_LOCK indefinitely.
6. Assert reset mid-RELEASE -> all outputs return to their reset values asynchronously; 16 forced RUN losses -> loss_count saturates at 15.
